// File: rtl/twiddle_pkg.sv
// twiddle_pkg: FSM and quadrant encodings plus the elaboration-time quarter-wave cosine table builder.
package twiddle_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;
  localparam real PI = 3.14159265358979323846;
  function automatic int tw_cos(int m, int n_log2, int frac_w);
    return $rtoi($floor($cos(2.0 * PI * m / (2.0 ** n_log2)) * (2.0 ** frac_w)));
  endfunction
endpackage

// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: request, sweep-control and twiddle-output handshake bundle.
interface twiddle_gen_if #(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16,
  parameter int SW = $clog2(N_LOG2)
);
  logic req_valid, req_ready, inverse, sweep_start, busy, sweep_done, tw_valid, tw_ready;
  logic [SW-1:0] req_stage;
  logic [N_LOG2-2:0] req_index;
  logic [DATA_W-1:0] tw_re, tw_im;
  modport master (
    output req_valid, req_stage, req_index, inverse, sweep_start, tw_ready,
    input req_ready, busy, sweep_done, tw_valid, tw_re, tw_im
  );
  modport slave (
    input req_valid, req_stage, req_index, inverse, sweep_start, tw_ready,
    output req_ready, busy, sweep_done, tw_valid, tw_re, tw_im
  );
endinterface

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: dual-read synchronous quarter-wave cosine ROM; reads advance with the pipeline.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int FRAC_W = 8,
  parameter int AW = N_LOG2 - 1
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic [AW-1:0]   addr_a_i,
  input  logic [AW-1:0]   addr_b_i,
  output logic [FRAC_W:0] data_a_o,
  output logic [FRAC_W:0] data_b_o
);
  localparam int QTR = 1 << (N_LOG2 - 2);
  logic [FRAC_W:0] rom [1 << AW];
  logic [FRAC_W:0] data_a_q, data_b_q;
  // Only entries 0..N/4 are ever addressed; the rest are tied off.
  for (genvar g = 0; g < (1 << AW); g++) begin : g_rom
    assign rom[g] = (g <= QTR) ? (FRAC_W + 1)'(tw_cos(g, N_LOG2, FRAC_W)) : '0;
  end
  always_ff @(posedge clk) begin
    if (en_i) begin
      data_a_q <= rom[addr_a_i];
      data_b_q <= rom[addr_b_i];
    end
  end
  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;
endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: FFT twiddle generator with direct/sweep request mux and 3-stage quadrant-folding pipeline.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int SW = $clog2(N_LOG2)
) (
  input logic clk,
  input logic rst,
  twiddle_gen_if.slave bus
);
  localparam int IW = N_LOG2 - 1;
  localparam int RW = N_LOG2 - 2;
  localparam logic [IW-1:0] QTR = IW'(1 << RW);
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, iss_idx;
  logic [SW-1:0] stage_q, stage_d, req_s, iss_s;
  logic inv_q, inv_d, adv, idle, last, done, iss_v, iss_inv, iss_last;
  logic [N_LOG2-1:0] e;
  logic p1_v_q, p1_inv_q, p1_last_q, p2_v_q, p2_inv_q, p2_last_q, tw_v_q, tw_last_q;
  quad_t p1_quad_q, p2_quad_q;
  logic [RW-1:0] p1_r_q;
  logic [FRAC_W:0] t_a, t_b;
  logic [DATA_W-1:0] a_x, b_x, re_d, im_f, im_d, tw_re_q, tw_im_q;
  function automatic logic [IW-1:0] mask(logic [SW-1:0] s);
    return IW'((1 << s) - 1);
  endfunction
  assign adv = !tw_v_q || bus.tw_ready;
  assign idle = state_q == IDLE;
  assign req_s = (bus.req_stage > SW'(N_LOG2 - 1)) ? SW'(N_LOG2 - 1) : bus.req_stage;
  assign last = cnt_q == mask(stage_q);
  assign done = tw_v_q && bus.tw_ready && tw_last_q && state_q == DRAIN && !rst;
  // Direct requests own the pipeline while idle; the sweep counter owns it otherwise.
  assign iss_v = idle ? bus.req_valid : state_q == SWEEP;
  assign iss_s = idle ? req_s : stage_q;
  assign iss_idx = idle ? bus.req_index : cnt_q;
  assign iss_inv = idle ? bus.inverse : inv_q;
  assign iss_last = state_q == SWEEP && last;
  assign e = N_LOG2'({1'b0, iss_idx & mask(iss_s)} << (IW - iss_s));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    inv_d = inv_q;
    case (state_q)
      IDLE: if (bus.sweep_start && !bus.req_valid) begin
        state_d = SWEEP;
        cnt_d = '0;
        stage_d = req_s;
        inv_d = bus.inverse;
      end
      SWEEP: if (adv) begin
        cnt_d = cnt_q + 1'b1;
        state_d = last ? DRAIN : SWEEP;
      end
      DRAIN: state_d = done ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stage_q <= '0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      inv_q <= inv_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_v_q <= 1'b0;
      p2_v_q <= 1'b0;
      tw_v_q <= 1'b0;
      tw_re_q <= '0;
      tw_im_q <= '0;
    end else if (adv) begin
      p1_v_q <= iss_v;
      p2_v_q <= p1_v_q;
      tw_v_q <= p2_v_q;
      if (p2_v_q) begin
        tw_re_q <= re_d;
        tw_im_q <= im_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (adv) begin
      p1_quad_q <= quad_t'(e[N_LOG2-1 -: 2]);
      p1_r_q <= e[RW-1:0];
      p1_inv_q <= iss_inv;
      p1_last_q <= iss_last;
      p2_quad_q <= p1_quad_q;
      p2_inv_q <= p1_inv_q;
      p2_last_q <= p1_last_q;
      tw_last_q <= p2_last_q;
    end
  end
  twiddle_qrom #(.N_LOG2(N_LOG2), .FRAC_W(FRAC_W)) u_qrom (
    .clk(clk),
    .en_i(adv),
    .addr_a_i({1'b0, p1_r_q}),
    .addr_b_i(QTR - {1'b0, p1_r_q}),
    .data_a_o(t_a),
    .data_b_o(t_b)
  );
  assign a_x = DATA_W'(t_a);
  assign b_x = DATA_W'(t_b);
  always_comb begin
    re_d = (p2_quad_q == Q0) ? a_x : (p2_quad_q == Q1) ? -b_x : (p2_quad_q == Q2) ? -a_x : b_x;
    im_f = (p2_quad_q == Q0) ? -b_x : (p2_quad_q == Q1) ? -a_x : (p2_quad_q == Q2) ? b_x : a_x;
    im_d = p2_inv_q ? -im_f : im_f;
  end
  assign bus.req_ready = idle && adv && !rst;
  assign bus.busy = !idle;
  assign bus.sweep_done = done;
  assign bus.tw_valid = tw_v_q;
  assign bus.tw_re = tw_re_q;
  assign bus.tw_im = tw_im_q;
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed and randomized checks of twiddle_gen against a trigonometric reference model.
module tb_twiddle_gen;
  localparam int N_LOG2 = 5, DATA_W = 16, FRAC_W = 8, N = 1 << N_LOG2;
  localparam int SW = $clog2(N_LOG2), IW = N_LOG2 - 1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  twiddle_gen_if #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) bus ();
  twiddle_gen #(.N_LOG2(N_LOG2), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic [15:0] re, im; bit last; } exp_t;
  int n_vec = 0, n_err = 0;

  // Fixed point truncated toward zero: magnitude floored, sign applied afterwards.
  function automatic logic [15:0] fix(real x);
    real a = (x < 0.0) ? -x : x;
    int m = $rtoi($floor(a * (2.0 ** FRAC_W) + 1.0e-9));
    return (x < 0.0) ? 16'(-m) : 16'(m);
  endfunction

  // Stage s twiddle j is W_N^(j * N / 2^(s+1)), j = index mod 2^s.
  function automatic exp_t model(int s, int idx, bit inv, bit last);
    int sc = (s > N_LOG2 - 1) ? N_LOG2 - 1 : s;
    int e = (idx % (1 << sc)) * (N >> (sc + 1));
    real th = 2.0 * 3.14159265358979 * e / N;
    exp_t r;
    r.re = fix($cos(th));
    r.im = fix(inv ? $sin(th) : -$sin(th));
    r.last = last;
    return r;
  endfunction

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.sweep_start = 1'b0;
    bus.inverse = 1'b0;
    bus.req_stage = '0;
    bus.req_index = '0;
    bus.tw_ready = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_vec++; if ({bus.tw_valid, bus.busy, bus.sweep_done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.tw_valid, bus.busy, bus.sweep_done}); end
    n_vec++; if ({bus.tw_re, bus.tw_im} !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {bus.tw_re, bus.tw_im}); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_directed();
    int s_t[5] = '{4, 2, 2, 1, 0};
    int i_t[5] = '{1, 1, 1, 1, 0};
    bit v_t[5] = '{0, 0, 1, 0, 0};
    logic [15:0] re_t[5] = '{16'h00FB, 16'h00B5, 16'h00B5, 16'h0000, 16'h0100};
    logic [15:0] im_t[5] = '{16'hFFCF, 16'hFF4B, 16'h00B5, 16'hFF00, 16'h0000};
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      int lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_stage = SW'(s_t[k]);
      bus.req_index = IW'(i_t[k]);
      bus.inverse = v_t[k];
      #1;
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready: got %b want 1", k, bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      while (!bus.tw_valid && lat < 10) begin @(negedge clk); lat++; end
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 3", k, lat); end
      n_vec++; if (bus.tw_re !== re_t[k]) begin n_err++; $display("FAIL dir%0d_re: got %h want %h", k, bus.tw_re, re_t[k]); end
      n_vec++; if (bus.tw_im !== im_t[k]) begin n_err++; $display("FAIL dir%0d_im: got %h want %h", k, bus.tw_im, im_t[k]); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t x;
    int outs = 0, first = -1, lastc = -1;
    drive_idle();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.req_valid = c < 16;
      bus.req_stage = SW'($urandom_range(0, 7));
      bus.req_index = IW'($urandom);
      bus.inverse = 1'($urandom_range(0, 1));
      #1;
      if (c < 16) begin
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 1", c, bus.req_ready); end
        q.push_back(model(int'(bus.req_stage), int'(bus.req_index), bus.inverse, 1'b0));
      end
      if (bus.tw_valid) begin
        n_vec++;
        if (q.size() == 0) begin n_err++; $display("FAIL b2b_extra c%0d: got output want none", c); end
        else begin
          x = q.pop_front();
          if ({bus.tw_re, bus.tw_im} !== {x.re, x.im}) begin n_err++; $display("FAIL b2b_data c%0d: got %h/%h want %h/%h", c, bus.tw_re, bus.tw_im, x.re, x.im); end
        end
        if (first < 0) first = c;
        lastc = c;
        outs++;
      end
    end
    n_vec++; if (outs !== 16 || lastc - first !== 15 || first !== 3) begin n_err++; $display("FAIL b2b_stream: got %0d outs span %0d first %0d want 16/15/3", outs, lastc - first, first); end
  endtask

  task automatic test_sweep();
    logic [15:0] re_t[8] = '{16'h0100, 16'h00EC, 16'h00B5, 16'h0061, 16'h0000, 16'hFF9F, 16'hFF4B, 16'hFF14};
    int got = 0, first = -1, lastc = -1;
    drive_idle();
    @(negedge clk);
    bus.sweep_start = 1'b1;
    bus.req_stage = SW'(3);
    @(negedge clk);
    bus.sweep_start = 1'b0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      n_vec++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL sweep_busy c%0d: got busy %b ready %b want 1 0", c, bus.busy, bus.req_ready); end
      if (bus.tw_valid) begin
        n_vec++; if (bus.tw_re !== re_t[got]) begin n_err++; $display("FAIL sweep_re%0d: got %h want %h", got, bus.tw_re, re_t[got]); end
        n_vec++; if (bus.tw_im !== model(3, got, 0, 0).im) begin n_err++; $display("FAIL sweep_im%0d: got %h want %h", got, bus.tw_im, model(3, got, 0, 0).im); end
        n_vec++; if (bus.sweep_done !== (got == 7)) begin n_err++; $display("FAIL sweep_done%0d: got %b want %b", got, bus.sweep_done, got == 7); end
        if (first < 0) first = c;
        lastc = c;
        got++;
      end else begin
        n_vec++; if (bus.sweep_done !== 1'b0) begin n_err++; $display("FAIL sweep_done_idle c%0d: got 1 want 0", c); end
      end
      @(negedge clk);
    end
    n_vec++; if (got !== 8 || lastc - first !== 7) begin n_err++; $display("FAIL sweep_count: got %0d span %0d want 8/7", got, lastc - first); end
    n_vec++; if ({bus.busy, bus.tw_valid, bus.sweep_done} !== 3'b000) begin n_err++; $display("FAIL sweep_end: got %b want 000", {bus.busy, bus.tw_valid, bus.sweep_done}); end
  endtask

  task automatic test_sweep_stall();
    int got = 0, stalled = 0, dones = 0;
    bit acc;
    logic [15:0] h_re = '0, h_im = '0;
    exp_t x;
    drive_idle();
    @(negedge clk);
    bus.sweep_start = 1'b1;
    bus.req_stage = SW'(3);
    bus.inverse = 1'b1;
    @(negedge clk);
    bus.sweep_start = 1'b0;
    bus.inverse = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      bus.tw_ready = !(got == 3 && stalled < 5);
      #1;
      acc = bus.tw_valid && bus.tw_ready;
      if (!bus.tw_ready) begin
        n_vec++; if (bus.tw_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid%0d: got 0 want 1", stalled); end
        if (stalled == 0) begin h_re = bus.tw_re; h_im = bus.tw_im; end
        else begin
          n_vec++; if ({bus.tw_re, bus.tw_im} !== {h_re, h_im}) begin n_err++; $display("FAIL stall_hold%0d: got %h/%h want %h/%h", stalled, bus.tw_re, bus.tw_im, h_re, h_im); end
        end
        stalled++;
      end else if (acc) begin
        x = model(3, got, 1, 0);
        n_vec++; if ({bus.tw_re, bus.tw_im} !== {x.re, x.im}) begin n_err++; $display("FAIL stall_data%0d: got %h/%h want %h/%h", got, bus.tw_re, bus.tw_im, x.re, x.im); end
        got++;
      end
      n_vec++; if (bus.sweep_done !== (acc && got == 8)) begin n_err++; $display("FAIL stall_done c%0d: got %b want %b", c, bus.sweep_done, acc && got == 8); end
      dones += int'(bus.sweep_done);
      @(negedge clk);
    end
    n_vec++; if (got !== 8 || dones !== 1 || stalled !== 5 || bus.busy !== 1'b0 || bus.tw_valid !== 1'b0) begin n_err++; $display("FAIL stall_summary: got %0d dones %0d stalls %0d busy %b valid %b want 8 1 5 0 0", got, dones, stalled, bus.busy, bus.tw_valid); end
    bus.tw_ready = 1'b1;
  endtask

  task automatic test_reset_mid_sweep();
    int got = 0, lat = 1;
    bit bad = 0;
    drive_idle();
    @(negedge clk);
    bus.sweep_start = 1'b1;
    bus.req_stage = SW'(3);
    @(negedge clk);
    bus.sweep_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.tw_valid) begin
        if (got == 3) break;
        got++;
      end
      @(negedge clk);
    end
    n_vec++; if (got !== 3 || bus.tw_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_reach: got %0d outputs want 3 then 4th visible", got); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.tw_valid, bus.busy, bus.sweep_done} !== 3'b000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 000", {bus.tw_valid, bus.busy, bus.sweep_done}); end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      bad |= bus.tw_valid | bus.busy | bus.sweep_done;
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL rst_mid_quiet: got activity want none"); end
    bus.req_valid = 1'b1;
    bus.req_stage = SW'(4);
    bus.req_index = IW'(1);
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!bus.tw_valid && lat < 10) begin @(negedge clk); lat++; end
    n_vec++; if (lat !== 3 || bus.tw_re !== 16'h00FB || bus.tw_im !== 16'hFFCF) begin n_err++; $display("FAIL rst_mid_direct: got lat %0d %h/%h want 3 00fb/ffcf", lat, bus.tw_re, bus.tw_im); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t x;
    bit active = 0, was_active, exp_ready;
    int sc;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      bus.tw_ready = (c >= 600) || ($urandom_range(0, 3) != 0);
      bus.req_valid = (c < 600) && ($urandom_range(0, 2) == 0);
      bus.sweep_start = (c < 600) && ($urandom_range(0, 11) == 0);
      bus.req_stage = SW'($urandom_range(0, 7));
      bus.req_index = IW'($urandom);
      bus.inverse = 1'($urandom_range(0, 1));
      #1;
      was_active = active;
      exp_ready = !was_active && (!bus.tw_valid || bus.tw_ready);
      n_vec++; if (bus.req_ready !== exp_ready || bus.busy !== was_active) begin n_err++; $display("FAIL rnd_ctrl c%0d: got ready %b busy %b want %b %b", c, bus.req_ready, bus.busy, exp_ready, was_active); end
      if (bus.tw_valid && bus.tw_ready) begin
        n_vec++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_extra c%0d: got output %h/%h want none", c, bus.tw_re, bus.tw_im); end
        else begin
          x = q.pop_front();
          if ({bus.tw_re, bus.tw_im, bus.sweep_done} !== {x.re, x.im, x.last}) begin n_err++; $display("FAIL rnd_data c%0d: got %h/%h done %b want %h/%h done %b", c, bus.tw_re, bus.tw_im, bus.sweep_done, x.re, x.im, x.last); end
          if (x.last) active = 0;
        end
      end else begin
        n_vec++; if (bus.sweep_done !== 1'b0) begin n_err++; $display("FAIL rnd_done c%0d: got 1 want 0", c); end
      end
      if (bus.req_valid && exp_ready)
        q.push_back(model(int'(bus.req_stage), int'(bus.req_index), bus.inverse, 1'b0));
      else if (!was_active && bus.sweep_start && !bus.req_valid) begin
        sc = (int'(bus.req_stage) > N_LOG2 - 1) ? N_LOG2 - 1 : int'(bus.req_stage);
        for (int i = 0; i < (1 << sc); i++) q.push_back(model(sc, i, bus.inverse, i == (1 << sc) - 1));
        active = 1;
      end
    end
    n_vec++; if (q.size() !== 0 || active) begin n_err++; $display("FAIL rnd_drain: got %0d pending active %b want 0 0", q.size(), active); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_sweep();
    test_sweep_stall();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised FFT twiddle-factor generator for the CWT transform datapath. It produces complex factors W_N^e = cos(2πe/N) − j·sin(2πe/N) in signed fixed point. Values come from a quarter-wave cosine table with quadrant folding, so there is no full per-stage ROM. It serves two request sources, an external per-factor request port and an internal stage-sweep sequencer, and feeds the butterfly unit through a 3-stage valid/ready pipeline. An inverse mode returns the conjugate for IFFT passes.

## Interface
- `N_LOG2`, 5: log2 of FFT size N; N ≥ 8.
- `DATA_W`, 16: output word width, two's complement; must be ≥ FRAC_W+2.
- `FRAC_W`, 8: fractional bits; 1.0 = 2^FRAC_W (0x0100 at defaults).
- `SW`, derived: $clog2(N_LOG2), width of stage fields.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  direct request present.
- `req_ready`  out  1  direct request accepted when high with `req_valid`.
- `req_stage`  in  SW  butterfly stage s, 0..N_LOG2-1.
- `req_index`  in  N_LOG2-1  twiddle index within stage.
- `inverse`  in  1  conjugate output; sampled with each accepted request or sweep start.
- `sweep_start`  in  1  one-cycle pulse; begin sweep of `req_stage`; ignored while busy.
- `busy`  out  1  sweep in progress.
- `sweep_done`  out  1  one-cycle pulse when last sweep element is accepted at output.
- `tw_valid`  out  1  output factor valid.
- `tw_ready`  in  1  downstream accepts.
- `tw_re`, `tw_im`  out  DATA_W  real/imag factor.

## Operation
- Exponent: e = (index & (2^s−1)) << (N_LOG2−1−s), width N_LOG2. s ≥ N_LOG2 is clamped to N_LOG2−1.
- Table T[m], m = 0..N/4: floor(2^FRAC_W·cos(2πm/N)). T[0] = 2^FRAC_W, T[N/4] = 0. Negative outputs are the two's complement of T; −T is never re-floored.
- Quadrant q = e[N_LOG2-1:N_LOG2-2], r = e[N_LOG2-3:0]:
  - q0: re = +T[r], im = −T[N/4−r].
  - q1: re = −T[N/4−r], im = −T[r].
  - q2: re = −T[r], im = +T[N/4−r].
  - q3: re = +T[N/4−r], im = +T[r].
- `inverse` = 1 negates im after folding. −0 = 0.
- FSM states:
  - IDLE → SWEEP on `sweep_start`. Latch stage and inverse, counter cnt = 0.
  - SWEEP issues index cnt into the pipeline each advancing cycle, cnt++.
  - After issuing 2^s−1, SWEEP → DRAIN. DRAIN → IDLE when that element is accepted at the output. `sweep_done` pulses in the same cycle.
  - `busy` = state ≠ IDLE.
- `req_ready` = (state == IDLE) && adv && !rst, where adv = !tw_valid || tw_ready.
- `sweep_start` and `req_valid` in the same IDLE cycle: the direct request is taken and the sweep start is dropped. Sweeps start only with `req_valid` low.

## Timing
- Pipeline P1 (exponent/quadrant), P2 (two table reads), P3 (fold/sign/conjugate → output registers).
- Latency is 3 cycles from acceptance to `tw_valid` with no stall. Throughput is 1 per cycle.
- All stages advance only on adv; bubbles propagate as invalid.
- While `tw_valid` && !`tw_ready`, `tw_re`/`tw_im` hold stable and nothing is lost or duplicated.
- Reset clears all valids, `tw_re`/`tw_im` = 0, `busy` = 0, `sweep_done` = 0, FSM = IDLE, cnt = 0.
- Mid-sweep reset aborts the sweep, emits no `sweep_done`, and discards in-flight factors.

## Structure
- Package `twiddle_pkg`: FSM state enum (IDLE, SWEEP, DRAIN), the elaboration-time function building T[] with floor rounding, and the quadrant encoding constants.
- Sub-module `twiddle_qrom`: dual-read synchronous quarter-wave ROM, N/4+1 entries × (FRAC_W+1) bits, enable = adv. It is the P2 stage.
- Top: request mux, FSM, P1/P3 registers.

## Test plan
All at defaults (N = 32, FRAC_W = 8, DATA_W = 16).
- Direct (s=4, idx=1) → 3 cycles later re = 0x00FB, im = 0xFFCF.
- Direct (s=2, idx=1) → re = 0x00B5, im = 0xFF4B. Same request with inverse = 1 → im = 0x00B5.
- Direct (s=1, idx=1) → re = 0x0000, im = 0xFF00. Direct (s=0, idx=0) → re = 0x0100, im = 0x0000.
- Sweep s=3 with `tw_ready` = 1 → 8 consecutive re = 0100, 00EC, 00B5, 0061, 0000, FF9F, FF4B, FF14.
  - `sweep_done` pulses with the 8th output.
  - `req_ready` is low throughout.
- Sweep s=3 with `tw_ready` low for 5 cycles mid-stream → output held stable. All 8 values arrive exactly once, in order.
- Reset asserted at the 4th sweep output → next cycle `tw_valid` = 0, `busy` = 0, no `sweep_done`. A subsequent direct request behaves normally.
